cl_frame_to_stream: RTL and testbench
=====================================

Name: cl_frame_to_stream

Overview:
- Receives 512-bit cache lines (CLs), each with a 16-bit header and 496-bit payload.
- Buffers CLs in an internal FIFO until a complete AFU frame (start-CL through end-CL) is stored.
- Then replays the frame as a stream of 12-bit symbols with valid/ready, sop and eop.
- Sits between the host CL interface and the AFU symbol-stream input.

Parameters:
- CL, 512: cache-line width.
- CL_HEAD, 16: header width, bits [CL-1:CL-16].
- CL_PAYLOAD, 496: payload width, bits [CL_PAYLOAD-1:0].
- ST, 12: output symbol width.
- W_LEN, 10: width of the header length field.
- W_FRM_LEN, 16: width of the sb_len frame-length counter.
- DEPTH, 64: FIFO depth in CLs (power of 2).

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- sink_ready  out  1  FIFO can accept a CL.
- sink_data  in  CL  cache line.
- sink_valid  in  1  sink_data valid.
- source_ready  in  1  downstream accepts a symbol.
- source_data  out  ST  symbol.
- source_valid  out  1  source_data valid.
- source_sop  out  1  first symbol of frame.
- source_eop  out  1  last symbol of frame.
- sb_len  out  W_FRM_LEN  symbol count of the most recently completed stored frame.

Behaviour:
Reset and clocking:
- One clock domain; rst clears everything asynchronously.
- Reset values: FIFO empty, frame count 0, sink_ready=0 while rst is high, source_valid/sop/eop=0, source_data=0, sb_len=0.
- A reset mid-frame discards all buffered data.

Header format:
- [CL-1:CL-4] reserved, ignored.
- [CL-5:CL-6] flags: 10 = start of frame, 01 = end of frame, 00 = middle, 11 = single-CL frame (both start and end).
- [CL-7:CL-16] len: number of valid symbols in the CL.
- Effective len: 0 becomes 1; values above 41 (floor(496/12)) saturate to 41.
- Symbol k (k = 0..len-1) = payload[12k+11:12k], emitted LSB-first.

Sink side:
- sink_ready = FIFO not full.
- A CL is written when sink_valid & sink_ready; every such CL is stored.
- Each end-flag CL written increments the complete-frame count and latches sb_len = sum of effective len since the last start-flag CL.
- A start flag seen mid-frame restarts the sb_len accumulation only; no data is dropped.
- Writes while full cannot occur because sink_ready=0.

Source side, state machine IDLE -> LOAD -> SEND:
- IDLE: frame count > 0 -> LOAD.
- LOAD: pop one CL into a shift register, symbol index = 0 -> SEND.
- SEND: source_valid=1. On source_valid & source_ready, advance the index.
  - Last symbol of a non-end CL: pop the next CL in the same cycle, no bubble.
  - Last symbol of an end CL: decrement frame count, -> IDLE, or directly to LOAD if another frame is complete.
- source_sop = 1 on symbol 0 of a start-flag CL (flags 10 or 11).
- source_eop = 1 on the last symbol of an end-flag CL (flags 01 or 11).
- source_data, sop and eop hold stable while source_valid & !source_ready.

Latency and concurrency:
- First source_valid occurs exactly 2 cycles after the end-CL write edge when the source is idle.
- A simultaneous write of an end-CL and read completion of a frame leaves the frame count unchanged (+1 and -1).
- Output never starts a frame until its end-CL is stored, so a started frame streams without gaps while source_ready=1.

Test Plan:
- Reset: rst high mid-stream -> sink_ready=0, source_valid=0, sb_len=0; after release, sink_ready=1 within 1 cycle.
- 16-CL frame, each len=1, first flag 10, last 01, one CL every 3 cycles, source_ready=1 -> exactly 16 symbols, each equal to payload[11:0] of its CL; sop on the 1st, eop on the 16th; sb_len=16; first symbol 2 cycles after the 16th write.
- Single CL, flags 11, len=41, payload symbols 1..41 -> 41 consecutive symbols 1..41, sop and eop both on the single-CL boundaries; len=0 case -> 1 symbol; len=50 -> 41 symbols.
- Backpressure: toggle source_ready every cycle during a 3-CL frame with len=5 -> 15 symbols in order, data/sop/eop held while stalled.
- Full: source_ready=0, write DEPTH CLs -> sink_ready=0 after the DEPTH-th write; release -> all frames drain intact.
- Back-to-back frames stored -> second frame's sop follows first frame's eop with at most 1 idle cycle.

Source files
------------

// File: rtl/cl_frame_to_stream.sv
// Cache-line frame buffer: stores whole AFU frames of 512-bit CLs in a FIFO,
// then replays each stored frame as a sop/eop-framed stream of 12-bit symbols.
module cl_frame_to_stream #(
  parameter int CL         = 512,
  parameter int CL_HEAD    = 16,
  parameter int CL_PAYLOAD = 496,
  parameter int ST         = 12,
  parameter int W_LEN      = 10,
  parameter int W_FRM_LEN  = 16,
  parameter int DEPTH      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 sink_ready,
  input  logic [CL-1:0]        sink_data,
  input  logic                 sink_valid,
  input  logic                 source_ready,
  output logic [ST-1:0]        source_data,
  output logic                 source_valid,
  output logic                 source_sop,
  output logic                 source_eop,
  output logic [W_FRM_LEN-1:0] sb_len
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXL = CL_PAYLOAD / ST;
  localparam int WL   = $clog2(MAXL + 1);
  localparam int HT   = CL_PAYLOAD + CL_HEAD - 5;
  localparam int MW   = 2 + W_LEN + CL_PAYLOAD;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  function automatic logic [WL-1:0] eff_len(input logic [W_LEN-1:0] l);
    if (l == '0) return WL'(1);
    if (l > W_LEN'(MAXL)) return WL'(MAXL);
    return l[WL-1:0];
  endfunction

  // FIFO entries drop the reserved header bits
  logic [MW-1:0]         mem_q [DEPTH];
  logic [MW-1:0]         w_ent, r_ent;
  logic [1:0]            w_flg, r_flg;
  logic [W_LEN-1:0]      w_len, r_len;
  logic [WL-1:0]         w_eff;
  logic [AW:0]           wr_q, rd_q, fcnt_q;
  logic [W_FRM_LEN-1:0]  acc_q, sb_len_q, acc_base;
  logic                  full, wr_en, inc, dec, pop, hs, last;

  state_t                st_q, st_d;
  logic [CL_PAYLOAD-1:0] sr_q, sr_d;
  logic [1:0]            flg_q, flg_d;
  logic [WL-1:0]         len_q, len_d, idx_q, idx_d;

  assign w_ent = {sink_data[HT -: 2+W_LEN], sink_data[CL_PAYLOAD-1:0]};
  assign w_flg = w_ent[MW-1 -: 2];
  assign w_len = w_ent[CL_PAYLOAD +: W_LEN];
  assign w_eff = eff_len(w_len);
  assign r_ent = mem_q[rd_q[AW-1:0]];
  assign r_flg = r_ent[MW-1 -: 2];
  assign r_len = r_ent[CL_PAYLOAD +: W_LEN];

  assign full = (wr_q[AW] != rd_q[AW]) &&
                (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign sink_ready = ~full & ~rst;
  assign wr_en = sink_valid & sink_ready;
  assign inc = wr_en & w_flg[0];
  assign acc_base = w_flg[1] ? '0 : acc_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= w_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      fcnt_q   <= '0;
      acc_q    <= '0;
      sb_len_q <= '0;
    end else begin
      if (wr_en) begin
        wr_q <= wr_q + (AW+1)'(1);
        if (w_flg[0]) begin
          sb_len_q <= acc_base + W_FRM_LEN'(w_eff);
          acc_q    <= '0;
        end else begin
          acc_q <= acc_base + W_FRM_LEN'(w_eff);
        end
      end
      if (pop) rd_q <= rd_q + (AW+1)'(1);
      unique case ({inc, dec})
        2'b10:   fcnt_q <= fcnt_q + (AW+1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign source_valid = (st_q == SEND);
  assign hs   = source_valid & source_ready;
  assign last = (idx_q == len_q - WL'(1));

  always_comb begin
    st_d  = st_q;
    sr_d  = sr_q;
    flg_d = flg_q;
    len_d = len_q;
    idx_d = idx_q;
    pop   = 1'b0;
    dec   = 1'b0;
    unique case (st_q)
      IDLE: if (fcnt_q != '0) st_d = LOAD;
      LOAD: begin
        pop  = 1'b1;
        st_d = SEND;
      end
      SEND: if (hs) begin
        if (!last) begin
          sr_d  = sr_q >> ST;
          idx_d = idx_q + WL'(1);
        end else if (flg_q[0]) begin
          dec  = 1'b1;
          // a frame completing on this very edge still counts
          st_d = (fcnt_q > (AW+1)'(1) || inc) ? LOAD : IDLE;
        end else begin
          pop = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
    if (pop) begin
      sr_d  = r_ent[CL_PAYLOAD-1:0];
      flg_d = r_flg;
      len_d = eff_len(r_len);
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      sr_q  <= '0;
      flg_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      st_q  <= st_d;
      sr_q  <= sr_d;
      flg_q <= flg_d;
      len_q <= len_d;
      idx_q <= idx_d;
    end
  end

  assign source_data = source_valid ? sr_q[ST-1:0] : '0;
  assign source_sop  = source_valid & flg_q[1] & (idx_q == '0);
  assign source_eop  = source_valid & flg_q[0] & last;
  assign sb_len      = sb_len_q;

endmodule

// File: tb/tb_cl_frame_to_stream.sv
// Directed bench for cl_frame_to_stream: framing, length rules, latency,
// backpressure hold, FIFO full, back-to-back frames and mid-stream reset.
module tb_cl_frame_to_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         sink_ready;
  logic [511:0] sink_data;
  logic         sink_valid;
  logic         source_ready;
  logic [11:0]  source_data;
  logic         source_valid;
  logic         source_sop;
  logic         source_eop;
  logic [15:0]  sb_len;

  cl_frame_to_stream dut (
    .clk          (clk),
    .rst          (rst),
    .sink_ready   (sink_ready),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .source_ready (source_ready),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .sb_len       (sb_len)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int last_wr = 0;
  int fv_cyc = 0;
  bit fv_arm = 0;
  bit eop_seen = 0;
  int eop_cyc = 0;
  int last_gap = 99;
  bit stall_p = 0;
  logic [14:0] stall_v;
  logic [13:0] sym_q[$];
  logic [13:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_p = 0;
    end else begin
      if (stall_p)
        chk("hold", {17'b0, source_valid, source_sop, source_eop,
                     source_data}, {17'b0, stall_v});
      if (source_valid && source_ready) begin
        sym_q.push_back({source_sop, source_eop, source_data});
        if (source_sop && eop_seen) last_gap = cyc - eop_cyc;
        if (source_eop) begin
          eop_seen = 1;
          eop_cyc  = cyc;
        end
      end
      if (fv_arm && source_valid) begin
        fv_cyc = cyc;
        fv_arm = 0;
      end
      stall_p = source_valid && !source_ready;
      stall_v = {1'b1, source_sop, source_eop, source_data};
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [511:0] mk(input logic [1:0] fl,
                                      input logic [9:0] len,
                                      input int base);
    logic [511:0] d = '0;
    d[511:508] = 4'hA;
    d[507:506] = fl;
    d[505:496] = len;
    d[495:492] = 4'h5;
    for (int k = 0; k < 41; k++) d[12*k +: 12] = 12'(base + k);
    return d;
  endfunction

  task automatic add_cl(input logic [511:0] d);
    logic [1:0] fl = d[507:506];
    logic [9:0] l = d[505:496];
    int e;
    e = (l == 0) ? 1 : (l > 41) ? 41 : int'(l);
    for (int k = 0; k < e; k++)
      exp_q.push_back({fl[1] && k == 0, fl[0] && k == e - 1,
                       d[12*k +: 12]});
  endtask

  task automatic put(input logic [511:0] d);
    int n = 0;
    sink_data  = d;
    sink_valid = 1;
    while (!sink_ready && n < 200) begin
      step(1);
      n++;
    end
    if (n == 200) chk("sink_ready_wait", {31'b0, sink_ready}, 1);
    step(1);
    sink_valid = 0;
    last_wr = cyc;
  endtask

  task automatic cmp_stream(input string tag);
    int n = 0;
    while (sym_q.size() < exp_q.size() && n < 3000) begin
      step(1);
      n++;
    end
    step(2);
    chk({tag, "_count"}, sym_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sym_q.size(); i++)
      chk(tag, {18'b0, sym_q[i]}, {18'b0, exp_q[i]});
    sym_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [511:0] d;
    int n;
    rst = 1;
    sink_valid = 0;
    sink_data = '0;
    source_ready = 1;
    step(3);
    chk("rst_sink_ready", {31'b0, sink_ready}, 0);
    chk("rst_valid", {31'b0, source_valid}, 0);
    chk("rst_sb_len", {16'b0, sb_len}, 0);
    chk("rst_data", {20'b0, source_data}, 0);
    rst = 0;
    #1;
    chk("rel_sink_ready", {31'b0, sink_ready}, 1);
    step(1);

    // 16 single-symbol CLs, one write every 3 cycles
    fv_arm = 1;
    for (int i = 0; i < 16; i++) begin
      d = mk((i == 0) ? 2'b10 : (i == 15) ? 2'b01 : 2'b00, 10'd1,
             i * 37 + 5);
      add_cl(d);
      put(d);
      if (i < 15) step(2);
    end
    chk("f16_sb_len", {16'b0, sb_len}, 16);
    cmp_stream("f16_sym");
    chk("f16_latency", fv_cyc - last_wr, 2);

    // single-CL frames: full, zero and oversized length
    d = mk(2'b11, 10'd41, 1);
    add_cl(d);
    put(d);
    chk("len41_sb_len", {16'b0, sb_len}, 41);
    cmp_stream("len41_sym");
    d = mk(2'b11, 10'd0, 100);
    add_cl(d);
    put(d);
    chk("len0_sb_len", {16'b0, sb_len}, 1);
    cmp_stream("len0_sym");
    d = mk(2'b11, 10'd50, 200);
    add_cl(d);
    put(d);
    chk("len50_sb_len", {16'b0, sb_len}, 41);
    cmp_stream("len50_sym");

    // 3-CL frame under toggling backpressure
    source_ready = 0;
    for (int i = 0; i < 3; i++) begin
      d = mk((i == 0) ? 2'b10 : (i == 2) ? 2'b01 : 2'b00, 10'd5,
             300 + 16 * i);
      add_cl(d);
      put(d);
    end
    chk("bp_sb_len", {16'b0, sb_len}, 15);
    for (int i = 0; i < 80; i++) begin
      step(1);
      source_ready = ~source_ready;
    end
    source_ready = 1;
    cmp_stream("bp_sym");

    // fill the FIFO with one 64-CL frame, then one more frame
    source_ready = 0;
    for (int i = 0; i < 64; i++) begin
      d = mk((i == 0) ? 2'b10 : (i == 63) ? 2'b01 : 2'b00, 10'd1,
             500 + 3 * i);
      add_cl(d);
      put(d);
    end
    chk("full_sink_ready", {31'b0, sink_ready}, 0);
    chk("full_sb_len", {16'b0, sb_len}, 64);
    d = mk(2'b11, 10'd3, 900);
    add_cl(d);
    put(d);
    source_ready = 1;
    cmp_stream("full_sym");
    chk("full_sb_len2", {16'b0, sb_len}, 3);

    // two stored frames replay back to back
    source_ready = 0;
    d = mk(2'b10, 10'd3, 1000);
    add_cl(d);
    put(d);
    d = mk(2'b01, 10'd3, 1100);
    add_cl(d);
    put(d);
    d = mk(2'b11, 10'd4, 1200);
    add_cl(d);
    put(d);
    eop_seen = 0;
    last_gap = 99;
    source_ready = 1;
    cmp_stream("b2b_sym");
    chk("b2b_gap_le2", {31'b0, last_gap <= 2}, 1);

    // reset while a frame is streaming
    for (int i = 0; i < 3; i++)
      put(mk((i == 0) ? 2'b10 : (i == 2) ? 2'b01 : 2'b00, 10'd41,
             1500 + 50 * i));
    n = 0;
    while (sym_q.size() < 10 && n < 500) begin
      step(1);
      n++;
    end
    rst = 1;
    #1;
    chk("mid_rst_sink_ready", {31'b0, sink_ready}, 0);
    chk("mid_rst_valid", {31'b0, source_valid}, 0);
    chk("mid_rst_sb_len", {16'b0, sb_len}, 0);
    chk("mid_rst_data", {20'b0, source_data}, 0);
    step(1);
    rst = 0;
    #1;
    chk("mid_rel_sink_ready", {31'b0, sink_ready}, 1);
    sym_q.delete();
    step(10);
    chk("mid_rel_nsym", sym_q.size(), 0);
    chk("mid_rel_valid", {31'b0, source_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
